// File: rtl/game_pkg.sv
// Shared game constants: state_fsm codes, sprite sizes, judge FSM states.
package game_pkg;

    localparam logic [1:0] GAME_INIT    = 2'd0;
    localparam logic [1:0] GAME_RUNNING = 2'd1;
    localparam logic [1:0] GAME_OVER    = 2'd2;
    localparam logic [1:0] GAME_SUCCESS = 2'd3;

    localparam int unsigned MARIO_W_PX       = 34;
    localparam int unsigned MARIO_H_PX       = 36;
    localparam int unsigned QUEUE_W_PX       = 44;
    localparam int unsigned QUEUE_H_PX       = 50;
    localparam int unsigned BARREL_ROLL_W_PX = 32;
    localparam int unsigned BARREL_FALL_W_PX = 42;
    localparam int unsigned BARREL_H_PX      = 24;

    typedef enum logic [2:0] {
        J_IDLE     = 3'd0,
        J_PLAY     = 3'd1,
        J_COOLDOWN = 3'd2,
        J_LOST     = 3'd3,
        J_WON      = 3'd4
    } judge_state_e;

    function automatic logic [10:0] sat_sub(
        input logic [10:0] a,
        input logic [10:0] b
    );
        return (a > b) ? (a - b) : 11'd0;
    endfunction

endpackage

// File: rtl/game_judge_if.sv
// Sprite positions in, game verdict out, between the movers and game_judge.
interface game_judge_if;

    logic       tick;
    logic       running;
    logic [9:0] mario_x;
    logic [8:0] mario_y;
    logic [9:0] barrel_x;
    logic [8:0] barrel_y;
    logic [9:0] barrel_w;
    logic [8:0] barrel_h;
    logic       barrel_active;
    logic [9:0] queue_x;
    logic [8:0] queue_y;
    logic       over;
    logic       success;
    logic       hit;
    logic [1:0] lives;
    logic       invuln;

    modport master (
        output tick, running,
        output mario_x, mario_y,
        output barrel_x, barrel_y,
        output barrel_w, barrel_h,
        output barrel_active,
        output queue_x, queue_y,
        input  over, success, hit,
        input  lives, invuln
    );

    modport slave (
        input  tick, running,
        input  mario_x, mario_y,
        input  barrel_x, barrel_y,
        input  barrel_w, barrel_h,
        input  barrel_active,
        input  queue_x, queue_y,
        output over, success, hit,
        output lives, invuln
    );

endinterface

// File: rtl/game_judge_box_overlap.sv
// Strict axis-aligned box overlap on 11-bit edges; touching edges miss.
module box_overlap (
    input  logic [10:0] ax_i,
    input  logic [10:0] ay_i,
    input  logic [10:0] aw_i,
    input  logic [10:0] ah_i,
    input  logic [10:0] bx_i,
    input  logic [10:0] by_i,
    input  logic [10:0] bw_i,
    input  logic [10:0] bh_i,
    output logic        hit_o
);

    logic x_ovl;
    logic y_ovl;

    assign x_ovl = (ax_i < bx_i + bw_i) && (bx_i < ax_i + aw_i);
    assign y_ovl = (ay_i < by_i + bh_i) && (by_i < ay_i + ah_i);
    assign hit_o = x_ovl && y_ovl;

endmodule

// File: rtl/game_judge.sv
// Per-tick game judge: debounced barrel/queen hits, lives, invulnerability.
// Define GAME_JUDGE_DEBUG_EN to add the dbg_o status word.
module game_judge
    import game_pkg::*;
#(
    parameter int unsigned MARIO_W      = MARIO_W_PX,
    parameter int unsigned MARIO_H      = MARIO_H_PX,
    parameter int unsigned QUEUE_W      = QUEUE_W_PX,
    parameter int unsigned QUEUE_H      = QUEUE_H_PX,
    parameter int unsigned HIT_CONFIRM  = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVULN_TICKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    game_judge_if.slave bus
`ifdef GAME_JUDGE_DEBUG_EN
    ,
    output logic [31:0] dbg_o
`endif
);

    localparam logic [2:0] S_IDLE = J_IDLE;
    localparam logic [2:0] S_PLAY = J_PLAY;
    localparam logic [2:0] S_COOL = J_COOLDOWN;
    localparam logic [2:0] S_LOST = J_LOST;
    localparam logic [2:0] S_WON  = J_WON;

    localparam logic [2:0] HC = 3'(HIT_CONFIRM);
    localparam logic [1:0] LV = 2'(LIVES);
    localparam logic [5:0] IT = 6'(INVULN_TICKS);

    logic        s1_tick_q;
    logic        s1_bact_q;
    logic [10:0] s1_mx_q, s1_my_q;
    logic [10:0] s1_bx_q, s1_by_q;
    logic [10:0] s1_bw_q, s1_bh_q;
    logic [10:0] s1_qx_q, s1_qy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tick_q <= 1'b0;
            s1_bact_q <= 1'b0;
            s1_mx_q   <= '0;
            s1_my_q   <= '0;
            s1_bx_q   <= '0;
            s1_by_q   <= '0;
            s1_bw_q   <= '0;
            s1_bh_q   <= '0;
            s1_qx_q   <= '0;
            s1_qy_q   <= '0;
        end else begin
            s1_tick_q <= bus.tick;
            if (bus.tick) begin
                s1_bact_q <= bus.barrel_active;
                s1_mx_q   <= {1'b0, bus.mario_x};
                s1_my_q   <= {2'b0, bus.mario_y};
                s1_bx_q   <= {1'b0, bus.barrel_x};
                s1_by_q   <= {2'b0, bus.barrel_y};
                s1_bw_q   <= {1'b0, bus.barrel_w};
                s1_bh_q   <= {2'b0, bus.barrel_h};
                // queen arrives as a centre point; convert to top-left
                s1_qx_q   <= sat_sub({1'b0, bus.queue_x},
                                     11'(QUEUE_W / 2));
                s1_qy_q   <= sat_sub({2'b0, bus.queue_y},
                                     11'(QUEUE_H / 2));
            end
        end
    end

    logic bar_ovl;
    logic que_ovl;

    box_overlap u_bar_ovl (
        .ax_i  (s1_mx_q),
        .ay_i  (s1_my_q),
        .aw_i  (11'(MARIO_W)),
        .ah_i  (11'(MARIO_H)),
        .bx_i  (s1_bx_q),
        .by_i  (s1_by_q),
        .bw_i  (s1_bw_q),
        .bh_i  (s1_bh_q),
        .hit_o (bar_ovl)
    );

    box_overlap u_que_ovl (
        .ax_i  (s1_mx_q),
        .ay_i  (s1_my_q),
        .aw_i  (11'(MARIO_W)),
        .ah_i  (11'(MARIO_H)),
        .bx_i  (s1_qx_q),
        .by_i  (s1_qy_q),
        .bw_i  (11'(QUEUE_W)),
        .bh_i  (11'(QUEUE_H)),
        .hit_o (que_ovl)
    );

    logic s2_tick_q;
    logic s2_bhit_q;
    logic s2_qhit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_tick_q <= 1'b0;
            s2_bhit_q <= 1'b0;
            s2_qhit_q <= 1'b0;
        end else begin
            s2_tick_q <= s1_tick_q;
            s2_bhit_q <= bar_ovl & s1_bact_q;
            s2_qhit_q <= que_ovl;
        end
    end

    logic [2:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [5:0] cd_q, cd_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [2:0] qcnt_q, qcnt_d;
    logic       hit_q, hit_d;
    logic [2:0] bcnt_nx, qcnt_nx;
    logic       bconf, qconf;

    always_comb begin
        bcnt_nx = 3'd0;
        qcnt_nx = 3'd0;
        if (s2_bhit_q)
            bcnt_nx = (bcnt_q == HC) ? HC : bcnt_q + 3'd1;
        if (s2_qhit_q)
            qcnt_nx = (qcnt_q == HC) ? HC : qcnt_q + 3'd1;
        // a confirm is the tick the count first reaches HC
        bconf = (bcnt_nx == HC) && (bcnt_q != HC);
        qconf = (qcnt_nx == HC) && (qcnt_q != HC);

        state_d = state_q;
        lives_d = lives_q;
        cd_d    = cd_q;
        bcnt_d  = bcnt_q;
        qcnt_d  = qcnt_q;
        hit_d   = 1'b0;

        if (!bus.running) begin
            state_d = S_IDLE;
            cd_d    = '0;
            bcnt_d  = '0;
            qcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PLAY;
                    lives_d = LV;
                    bcnt_d  = '0;
                    qcnt_d  = '0;
                end
                S_PLAY: if (s2_tick_q) begin
                    bcnt_d = bcnt_nx;
                    qcnt_d = qcnt_nx;
                    if (bconf) begin
                        hit_d   = 1'b1;
                        bcnt_d  = '0;
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = S_LOST;
                        end else if (qconf) begin
                            state_d = S_WON;
                        end else begin
                            state_d = S_COOL;
                            cd_d    = IT;
                        end
                    end else if (qconf) begin
                        state_d = S_WON;
                    end
                end
                S_COOL: if (s2_tick_q) begin
                    bcnt_d = '0;
                    qcnt_d = qcnt_nx;
                    cd_d   = cd_q - 6'd1;
                    if (qconf) begin
                        state_d = S_WON;
                        cd_d    = '0;
                    end else if (cd_q == 6'd1) begin
                        state_d = S_PLAY;
                    end
                end
                S_LOST, S_WON: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lives_q <= LV;
            cd_q    <= '0;
            bcnt_q  <= '0;
            qcnt_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cd_q    <= cd_d;
            bcnt_q  <= bcnt_d;
            qcnt_q  <= qcnt_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.over    = (state_q == S_LOST);
    assign bus.success = (state_q == S_WON);
    assign bus.invuln  = (state_q == S_COOL);
    assign bus.hit     = hit_q;
    assign bus.lives   = lives_q;

`ifdef GAME_JUDGE_DEBUG_EN
    assign dbg_o = {2'b00, state_q, lives_q, bus.invuln,
                    bcnt_q, qcnt_q, cd_q, 12'b0};
`endif

endmodule

// File: tb/tb_game_judge.sv
// Randomized and directed bench for game_judge against a rule-level model.
module tb_game_judge;

    localparam int HC = 2;
    localparam int LV = 3;
    localparam int IT = 32;
    localparam int MW = 34;
    localparam int MH = 36;
    localparam int QW = 44;
    localparam int QH = 50;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_COOL = 2;
    localparam int M_LOST = 3;
    localparam int M_WON  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_judge_if bus ();
`ifdef GAME_JUDGE_DEBUG_EN
    logic [31:0] dbg;
`endif

    game_judge #(
        .HIT_CONFIRM  (HC),
        .LIVES        (LV),
        .INVULN_TICKS (IT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef GAME_JUDGE_DEBUG_EN
        ,
        .dbg_o (dbg)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int hits_seen = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0t: got %0d expected %0d",
                         nm, $time, act, exp);
        end
    endtask

    // Rule-level model: tick events reach the judge after a
    // 3-stage latency; game rules are applied per clock.
    int m_mode, m_lives, m_bc, m_qc, m_cd;
    bit m_hit;
    bit pv[2], pb[2], pq[2];
    bit cv, cb, cq;

    function automatic bit ovl(input int ax, input int ay,
                               input int aw, input int ah,
                               input int bx, input int by,
                               input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic int inc_sat(input int v);
        return (v + 1 > HC) ? HC : v + 1;
    endfunction

    task automatic model_step();
        int pbc, pqc;
        bit bconf, qconf;
        bconf = 1'b0;
        m_hit = 1'b0;
        if (!bus.running) begin
            m_mode = M_IDLE;
            m_bc = 0; m_qc = 0; m_cd = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_PLAY;
            m_lives = LV;
            m_bc = 0; m_qc = 0;
        end else if (cv && (m_mode == M_PLAY || m_mode == M_COOL)) begin
            pbc = m_bc;
            pqc = m_qc;
            m_qc = cq ? inc_sat(m_qc) : 0;
            qconf = (m_qc == HC) && (pqc < HC);
            if (m_mode == M_PLAY) begin
                m_bc = cb ? inc_sat(m_bc) : 0;
                bconf = (m_bc == HC) && (pbc < HC);
                if (bconf) begin
                    m_hit = 1'b1;
                    m_bc = 0;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_mode = M_LOST;
                    else if (qconf) m_mode = M_WON;
                    else begin
                        m_mode = M_COOL;
                        m_cd = IT;
                    end
                end else if (qconf) begin
                    m_mode = M_WON;
                end
            end else begin
                m_bc = 0;
                m_cd = m_cd - 1;
                if (qconf) m_mode = M_WON;
                else if (m_cd == 0) m_mode = M_PLAY;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int qx, qy;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_lives = LV;
            m_bc = 0; m_qc = 0; m_cd = 0;
            m_hit = 1'b0;
            for (int i = 0; i < 2; i++) begin
                pv[i] = 0; pb[i] = 0; pq[i] = 0;
            end
        end else begin
            cv = pv[1]; cb = pb[1]; cq = pq[1];
            pv[1] = pv[0]; pb[1] = pb[0]; pq[1] = pq[0];
            qx = int'(bus.queue_x) - QW / 2;
            qy = int'(bus.queue_y) - QH / 2;
            if (qx < 0) qx = 0;
            if (qy < 0) qy = 0;
            pv[0] = bus.tick;
            pb[0] = bus.barrel_active &&
                    ovl(bus.mario_x, bus.mario_y, MW, MH,
                        bus.barrel_x, bus.barrel_y,
                        bus.barrel_w, bus.barrel_h);
            pq[0] = ovl(bus.mario_x, bus.mario_y, MW, MH,
                        qx, qy, QW, QH);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (bus.hit === 1'b1) hits_seen++;
        if (checking) begin
            chk("over",    32'(bus.over),    int'(m_mode == M_LOST));
            chk("success", 32'(bus.success), int'(m_mode == M_WON));
            chk("invuln",  32'(bus.invuln),  int'(m_mode == M_COOL));
            chk("hit",     32'(bus.hit),     int'(m_hit));
            chk("lives",   32'(bus.lives),   m_lives);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            repeat (gap) cyc();
        end
    endtask

    task automatic settle();
        repeat (3) cyc();
    endtask

    task automatic restart();
        bus.running = 1'b0;
        cyc();
        bus.running = 1'b1;
        cyc();
    endtask

    task automatic place(input int mx, input int my,
                         input int bx, input int by,
                         input bit act,
                         input int qx, input int qy);
        bus.mario_x = 10'(mx);
        bus.mario_y = 9'(my);
        bus.barrel_x = 10'(bx);
        bus.barrel_y = 9'(by);
        bus.barrel_w = 10'd32;
        bus.barrel_h = 9'd24;
        bus.barrel_active = act;
        bus.queue_x = 10'(qx);
        bus.queue_y = 9'(qy);
    endtask

    task automatic hit_and_cool();
        ticks(2, 0);
        settle();
        ticks(IT, 0);
        settle();
    endtask

    bit edge_mode;
    int h0;

    initial begin
        bus.tick = 1'b0;
        bus.running = 1'b0;
        place(100, 200, 134, 200, 1'b1, 600, 400);
        rst_n = 1'b0;
        repeat (2) cyc();
        checking = 1'b1;
        chk("rst_over",    32'(bus.over), 0);
        chk("rst_success", 32'(bus.success), 0);
        chk("rst_hit",     32'(bus.hit), 0);
        chk("rst_lives",   32'(bus.lives), 3);
        chk("rst_invuln",  32'(bus.invuln), 0);
        rst_n = 1'b1;
        cyc();
        bus.running = 1'b1;
        cyc();

        ticks(5, 1);
        settle();
        chk("touch_hits",  hits_seen, 0);
        chk("touch_lives", 32'(bus.lives), 3);

        place(100, 200, 120, 210, 1'b1, 600, 400);
        ticks(1, 3);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk("lat_c1", 32'(bus.hit), 0);
        cyc();
        chk("lat_c2", 32'(bus.hit), 0);
        cyc();
        chk("lat_c3", 32'(bus.hit), 1);
        chk("hit1_lives",  32'(bus.lives), 2);
        chk("hit1_invuln", 32'(bus.invuln), 1);
        ticks(IT, 0);
        settle();
        chk("cool_nohit",  hits_seen, 1);
        chk("cool_end",    32'(bus.invuln), 0);
        hit_and_cool();
        ticks(2, 0);
        settle();
        chk("three_hits",  hits_seen, 3);
        chk("dead_lives",  32'(bus.lives), 0);
        chk("dead_over",   32'(bus.over), 1);
        ticks(3, 1);
        chk("over_held",   32'(bus.over), 1);
        bus.running = 1'b0;
        cyc();
        chk("over_clear",  32'(bus.over), 0);
        chk("lives_kept",  32'(bus.lives), 0);
        bus.running = 1'b1;
        cyc();
        chk("lives_restore", 32'(bus.lives), 3);

        place(44, 0, 500, 400, 1'b0, 10, 10);
        ticks(2, 0);
        settle();
        chk("queen_edge", 32'(bus.success), 0);
        place(43, 49, 500, 400, 1'b0, 10, 10);
        ticks(2, 0);
        settle();
        chk("queen_sat", 32'(bus.success), 1);
        restart();
        place(100, 20, 500, 400, 1'b0, 122, 43);
        ticks(2, 0);
        settle();
        chk("queen_won",  32'(bus.success), 1);
        chk("queen_over", 32'(bus.over), 0);
        restart();

        place(100, 20, 110, 25, 1'b1, 600, 400);
        hit_and_cool();
        bus.queue_x = 10'd122;
        bus.queue_y = 9'd43;
        ticks(2, 0);
        settle();
        chk("both2_lives",   32'(bus.lives), 1);
        chk("both2_success", 32'(bus.success), 1);
        restart();
        place(100, 20, 110, 25, 1'b1, 600, 400);
        hit_and_cool();
        hit_and_cool();
        bus.queue_x = 10'd122;
        bus.queue_y = 9'd43;
        ticks(2, 0);
        settle();
        chk("both1_over",    32'(bus.over), 1);
        chk("both1_success", 32'(bus.success), 0);
        chk("both1_lives",   32'(bus.lives), 0);
        restart();

        place(100, 20, 110, 25, 1'b1, 600, 400);
        h0 = hits_seen;
        ticks(1, 3);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        rst_n = 1'b0;
        repeat (2) cyc();
        chk("rstmid_hits",   hits_seen, h0);
        chk("rstmid_hit",    32'(bus.hit), 0);
        chk("rstmid_lives",  32'(bus.lives), 3);
        chk("rstmid_invuln", 32'(bus.invuln), 0);
        chk("rstmid_over",   32'(bus.over), 0);
        rst_n = 1'b1;
        cyc();

        edge_mode = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (c % 800 == 0) edge_mode = ~edge_mode;
            if ($urandom_range(3) == 0) begin
                if (!edge_mode) begin
                    bus.mario_x  = 10'(300 + $urandom_range(40));
                    bus.mario_y  = 9'(200 + $urandom_range(30));
                    bus.barrel_x = 10'(270 + $urandom_range(90));
                    bus.barrel_y = 9'(180 + $urandom_range(70));
                end else begin
                    bus.mario_x  = 10'(990 + $urandom_range(33));
                    bus.mario_y  = 9'(470 + $urandom_range(41));
                    bus.barrel_x = 10'(960 + $urandom_range(63));
                    bus.barrel_y = 9'(450 + $urandom_range(61));
                end
                bus.barrel_w = $urandom_range(1) ? 10'd32 : 10'd42;
                bus.barrel_h = 9'd24;
                bus.barrel_active = ($urandom_range(7) != 0);
                if ($urandom_range(15) == 0) begin
                    bus.queue_x = 10'(int'(bus.mario_x)
                                  - $urandom_range(20));
                    bus.queue_y = 9'(int'(bus.mario_y)
                                  - $urandom_range(20));
                end else begin
                    bus.queue_x = 10'd800;
                    bus.queue_y = 9'd60;
                end
            end
            bus.tick = ($urandom_range(2) == 0);
            if ($urandom_range(299) == 0)
                bus.running = 1'b0;
            else if (!bus.running && $urandom_range(3) == 0)
                bus.running = 1'b1;
            rst_n = ($urandom_range(1999) != 0);
            cyc();
        end
        bus.tick = 1'b0;
        rst_n = 1'b1;
        settle();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
